regalu_sequencer: RTL and testbench
===================================

Name: regalu_sequencer

Overview:
Command-driven controller that sequences the register bank and ALU datapath: it replaces switch-by-switch address entry with a queued command interface.
Each command (dst, src1, src2, op, no-writeback flag) is buffered, then stepped through READ → EXEC → WRITE → RESP, driving register bank addresses and strobes and the ALU op.
The block captures the ALU result and flags and returns them on a valid/ready response channel.
A step_en input gates all FSM advancement so the board's slow clock or push-button stepping can single-step the sequence.

Parameters:
ADDR_W, 5, register address width (32 registers)
DATA_W, 32, ALU/register data width
OP_W, 4, ALU function code width
DEPTH, 2, command FIFO depth (power of two, ≥2)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
step_en  in  1  FSM advance / FIFO pop enable (1 = advance this cycle)
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO not full
cmd_wdst  in  ADDR_W  write-back register
cmd_src1  in  ADDR_W  read port 1 register
cmd_src2  in  ADDR_W  read port 2 register
cmd_op  in  OP_W  ALU function
cmd_nowb  in  1  1 = skip register write-back
rf_raddr1  out  ADDR_W  register bank read address 1
rf_raddr2  out  ADDR_W  register bank read address 2
rf_waddr  out  ADDR_W  register bank write address
rf_rd  out  1  register bank read strobe
rf_wr  out  1  register bank write strobe
alu_op  out  OP_W  ALU function select
alu_result  in  DATA_W  ALU output, also the register bank write data
alu_zero  in  1  ALU zero flag
alu_sign  in  1  ALU sign flag
alu_over  in  1  ALU overflow flag
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_result  out  DATA_W  captured ALU result
rsp_flags  out  3  {over, sign, zero} captured
busy  out  1  FSM not in IDLE or FIFO not empty
state_dbg  out  3  current state encoding, for LEDs

Behaviour:
- Reset (sync, rst=1 at posedge, overrides everything including step_en):
  - state=IDLE; FIFO emptied.
  - All outputs 0, except cmd_ready=1.
  - Mid-operation reset abandons the command; rf_wr is low the cycle after the reset edge; no partial write is re-issued.
- FIFO:
  - Push on cmd_valid && cmd_ready; cmd_ready = !full.
  - Pop only in IDLE when !empty && step_en.
  - Push and pop in the same cycle are legal when not full; count is unchanged.
  - Pointers wrap modulo DEPTH.
- Address/op registers: rf_raddr1/2, rf_waddr, alu_op and the nowb bit are loaded at the pop edge and held constant until the next pop.
- States (all transitions require step_en=1; with step_en=0 the state and all registers hold and rf_rd/rf_wr are 0):
  - IDLE (0): if FIFO non-empty, pop → READ.
  - READ (1): rf_rd = step_en (one-cycle pulse); → EXEC.
  - EXEC (2): regbank outputs valid, ALU combinational; capture alu_result → rsp_result and flags → rsp_flags. Go → WRITE if nowb=0, else → RESP.
  - WRITE (3): rf_wr = step_en; regbank writes alu_result to rf_waddr (ALU inputs stable because addresses and op are held); → RESP.
  - RESP (4): rsp_valid=1. Leave to IDLE when rsp_ready=1, which does not require step_en. rsp_result and rsp_flags hold until the next EXEC capture.
- Latency with step_en=1 constant: pop edge → rsp_valid high after 4 cycles (3 with nowb).
- Throughput: one command per 5 cycles (4 with nowb).
- src equal to wdst is legal: read precedes write, so no hazard. Commands execute strictly in order.
- busy = (state!=IDLE) || !empty.
- state_dbg = state encoding above.

Decomposition:
- Shared package holds:
  - state enum {IDLE=0, READ=1, EXEC=2, WRITE=3, RESP=4};
  - command struct {wdst, src1, src2, op, nowb};
  - flag bit indices ZERO=0, SIGN=1, OVER=2;
  - the ALU op code constants used by the ALU.
- One sub-module: regalu_cmd_fifo (parameterised sync FIFO of the command struct, sync active-high rst).

Test Plan:
- Single command: push {wdst=3, src1=1, src2=2, op=ADD, nowb=0}, step_en=1, bench ALU model returns 32'h0000_0007 → rf_rd pulses 1 cycle after pop, rf_wr pulses with rf_waddr=3, rsp_valid 4 cycles after pop, rsp_result=7, rsp_flags=3'b000.
- No write-back and flags: nowb=1, alu_result=32'h8000_0000, sign=1 → rf_wr never asserted, rsp_valid 3 cycles after pop, rsp_flags=3'b010.
- Back-pressure and FIFO full: push 3 commands back-to-back with rsp_ready=0 → cmd_ready drops after 2 buffered while the FSM is in RESP. Release rsp_ready → commands complete in push order; cmd_ready returns to 1.
- Step gating: toggle step_en 1-0-0-1 each cycle → state advances only on step_en=1 cycles; rf_rd/rf_wr never high while step_en=0; results identical to the free-running case.
- Reset mid-WRITE: assert rst in the cycle state=WRITE → next cycle state_dbg=0, rf_wr=0, rsp_valid=0, busy=0, cmd_ready=1; FIFO contents discarded.
- src=dst: {wdst=5, src1=5, src2=5} → the write follows the read; rsp_result reflects pre-write register values.

Source files
------------

// File: rtl/regalu_sequencer_pkg.sv
// Shared types and constants for the register-bank/ALU command sequencer.
package regalu_sequencer_pkg;

    // Default datapath geometry; the command struct is built from these.
    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam int OP_W_DEF   = 4;
    localparam int DEPTH_DEF  = 2;

    // Sequencer states; the encoding is exported on state_dbg for the LEDs.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        EXEC  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_e;

    // One queued command.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] wdst;
        logic [ADDR_W_DEF-1:0] src1;
        logic [ADDR_W_DEF-1:0] src2;
        logic [OP_W_DEF-1:0]   op;
        logic                  nowb;
    } cmd_t;

    // Bit positions inside rsp_flags.
    localparam int FLAG_ZERO = 0;
    localparam int FLAG_SIGN = 1;
    localparam int FLAG_OVER = 2;

    // ALU function codes understood by the board ALU.
    localparam logic [OP_W_DEF-1:0] ALU_ADD = 4'h0;
    localparam logic [OP_W_DEF-1:0] ALU_SUB = 4'h1;
    localparam logic [OP_W_DEF-1:0] ALU_AND = 4'h2;
    localparam logic [OP_W_DEF-1:0] ALU_OR  = 4'h3;
    localparam logic [OP_W_DEF-1:0] ALU_XOR = 4'h4;
    localparam logic [OP_W_DEF-1:0] ALU_SLT = 4'h5;
    localparam logic [OP_W_DEF-1:0] ALU_SLL = 4'h6;
    localparam logic [OP_W_DEF-1:0] ALU_SRL = 4'h7;

    // Assemble the three ALU flags into the response flag vector.
    function automatic logic [2:0] pack_flags(input logic over, input logic sign, input logic zero);
        logic [2:0] f;
        f            = 3'b000;
        f[FLAG_ZERO] = zero;
        f[FLAG_SIGN] = sign;
        f[FLAG_OVER] = over;
        return f;
    endfunction

endpackage

// File: rtl/regalu_sequencer_if.sv
// Command, register-bank, ALU and response signals of the sequencer.
// master = environment side (command source, regbank/ALU, response sink),
// slave  = the sequencer itself.
interface regalu_sequencer_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_wdst;
    logic [ADDR_W-1:0] cmd_src1;
    logic [ADDR_W-1:0] cmd_src2;
    logic [OP_W-1:0]   cmd_op;
    logic              cmd_nowb;

    logic [ADDR_W-1:0] rf_raddr1;
    logic [ADDR_W-1:0] rf_raddr2;
    logic [ADDR_W-1:0] rf_waddr;
    logic              rf_rd;
    logic              rf_wr;

    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_sign;
    logic              alu_over;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic [2:0]        rsp_flags;

    modport master (
        output cmd_valid, cmd_wdst, cmd_src1, cmd_src2, cmd_op, cmd_nowb,
        output alu_result, alu_zero, alu_sign, alu_over,
        output rsp_ready,
        input  cmd_ready,
        input  rf_raddr1, rf_raddr2, rf_waddr, rf_rd, rf_wr,
        input  alu_op,
        input  rsp_valid, rsp_result, rsp_flags
    );

    modport slave (
        input  cmd_valid, cmd_wdst, cmd_src1, cmd_src2, cmd_op, cmd_nowb,
        input  alu_result, alu_zero, alu_sign, alu_over,
        input  rsp_ready,
        output cmd_ready,
        output rf_raddr1, rf_raddr2, rf_waddr, rf_rd, rf_wr,
        output alu_op,
        output rsp_valid, rsp_result, rsp_flags
    );
endinterface

// File: rtl/regalu_cmd_fifo.sv
// Synchronous command FIFO; DEPTH must be a power of two so pointers wrap naturally.
module regalu_cmd_fifo
    import regalu_sequencer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  cmd_t wdata_i,
    input  logic pop_i,
    output cmd_t rdata_o,
    output logic full_o,
    output logic empty_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    cmd_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign rdata_o   = mem_q[rd_ptr_q];

    // Storage array; contents are don't-care while the entry is not counted.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/regalu_sequencer.sv
// Queued command sequencer: steps each command through READ, EXEC, WRITE
// and RESP, driving the register bank strobes and ALU op, and returns the
// captured ALU result and flags on a valid/ready response channel.
module regalu_sequencer
    import regalu_sequencer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step_en,
    regalu_sequencer_if.slave   bus,
    output logic                busy,
    output logic [2:0]          state_dbg
);
    state_e            state_q;
    state_e            state_d;
    cmd_t              cmd_q;
    cmd_t              cmd_in_s;
    cmd_t              fifo_rdata_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              pop_s;
    logic              rf_rd_s;
    logic              rf_wr_s;
    logic              capture_s;
    logic [DATA_W-1:0] rsp_result_q;
    logic [2:0]        rsp_flags_q;

    assign cmd_in_s.wdst = bus.cmd_wdst;
    assign cmd_in_s.src1 = bus.cmd_src1;
    assign cmd_in_s.src2 = bus.cmd_src2;
    assign cmd_in_s.op   = bus.cmd_op;
    assign cmd_in_s.nowb = bus.cmd_nowb;

    regalu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.cmd_valid),
        .wdata_i (cmd_in_s),
        .pop_i   (pop_s),
        .rdata_o (fifo_rdata_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Next-state and strobe decode; nothing moves without step_en except leaving RESP.
    always_comb begin
        state_d   = state_q;
        pop_s     = 1'b0;
        rf_rd_s   = 1'b0;
        rf_wr_s   = 1'b0;
        capture_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (step_en && !fifo_empty_s) begin
                    pop_s   = 1'b1;
                    state_d = READ;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (step_en) begin
                    rf_rd_s = 1'b1;
                    state_d = EXEC;
                end else begin
                    state_d = READ;
                end
            end
            EXEC: begin
                if (step_en) begin
                    capture_s = 1'b1;
                    state_d   = cmd_q.nowb ? RESP : WRITE;
                end else begin
                    state_d = EXEC;
                end
            end
            WRITE: begin
                if (step_en) begin
                    rf_wr_s = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = WRITE;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Active command: addresses and op stay stable from pop until the next pop,
    // so the ALU inputs are still valid while WRITE stores its output.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q <= '0;
        end else if (pop_s) begin
            cmd_q <= fifo_rdata_s;
        end else begin
            cmd_q <= cmd_q;
        end
    end

    // Response capture in EXEC; held through RESP and beyond until the next EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_result_q <= {DATA_W{1'b0}};
            rsp_flags_q  <= 3'b000;
        end else if (capture_s) begin
            rsp_result_q <= bus.alu_result;
            rsp_flags_q  <= pack_flags(bus.alu_over, bus.alu_sign, bus.alu_zero);
        end else begin
            rsp_result_q <= rsp_result_q;
            rsp_flags_q  <= rsp_flags_q;
        end
    end

    assign bus.cmd_ready  = !fifo_full_s;
    assign bus.rf_raddr1  = ADDR_W'(cmd_q.src1);
    assign bus.rf_raddr2  = ADDR_W'(cmd_q.src2);
    assign bus.rf_waddr   = ADDR_W'(cmd_q.wdst);
    assign bus.rf_rd      = rf_rd_s;
    assign bus.rf_wr      = rf_wr_s;
    assign bus.alu_op     = OP_W'(cmd_q.op);
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;
    assign busy           = (state_q != IDLE) || !fifo_empty_s;
    assign state_dbg      = state_q;
endmodule

// File: tb/tb_regalu_sequencer.sv
// Directed bench for regalu_sequencer with a small register bank and ALU model.
module tb_regalu_sequencer;
    import regalu_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        step_en;
    logic        busy;
    logic [2:0]  state_dbg;
    int          checks = 0;
    int          errors = 0;

    regalu_sequencer_if #(.ADDR_W(5), .DATA_W(32), .OP_W(4)) bus ();

    regalu_sequencer #(.ADDR_W(5), .DATA_W(32), .OP_W(4), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .step_en   (step_en),
        .bus       (bus),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    // Register bank model: registered read on rf_rd, write on rf_wr.
    logic [31:0] regs [32];
    logic [31:0] rd1_q, rd2_q;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
            regs[1] <= 32'd3;
            regs[2] <= 32'd4;
            regs[5] <= 32'd10;
            regs[6] <= 32'h8000_0000;
            regs[7] <= 32'h7fff_ffff;
            regs[8] <= 32'd1;
            rd1_q   <= 32'd0;
            rd2_q   <= 32'd0;
        end else begin
            if (bus.rf_rd) begin
                rd1_q <= regs[bus.rf_raddr1];
                rd2_q <= regs[bus.rf_raddr2];
            end
            if (bus.rf_wr) regs[bus.rf_waddr] <= bus.alu_result;
        end
    end

    // ALU model.
    always_comb begin
        logic [31:0] r;
        logic        ov;
        ov = 1'b0;
        case (bus.alu_op)
            ALU_ADD: begin r = rd1_q + rd2_q; ov = (rd1_q[31] == rd2_q[31]) && (r[31] != rd1_q[31]); end
            ALU_SUB: begin r = rd1_q - rd2_q; ov = (rd1_q[31] != rd2_q[31]) && (r[31] != rd1_q[31]); end
            ALU_AND: r = rd1_q & rd2_q;
            ALU_OR:  r = rd1_q | rd2_q;
            ALU_XOR: r = rd1_q ^ rd2_q;
            default: r = 32'd0;
        endcase
        bus.alu_result = r;
        bus.alu_zero   = (r == 32'd0);
        bus.alu_sign   = r[31];
        bus.alu_over   = ov;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Offer one command and hold it until accepted (bounded).
    task automatic push_cmd(input logic [4:0] wdst, input logic [4:0] s1, input logic [4:0] s2,
                            input logic [3:0] op, input logic nowb);
        int w;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_wdst  = wdst;
        bus.cmd_src1  = s1;
        bus.cmd_src2  = s2;
        bus.cmd_op    = op;
        bus.cmd_nowb  = nowb;
        w = 0;
        while (!bus.cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) check("push_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    typedef struct {
        logic [4:0]  wdst;
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic [3:0]  op;
        logic        nowb;
        logic [31:0] exp_res;
        logic [2:0]  exp_flags;
        logic [31:0] exp_reg;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int          lat, rd_cnt, wr_cnt, got, viol, st_before, en_edge;
        logic [4:0]  wr_addr;
        logic [31:0] res_q [3];
        logic [2:0]  flg_q [3];
        logic        pat [4];
        logic [31:0] g_res;
        logic [2:0]  g_flg;

        vecs[0] = '{5'd3,  5'd1,  5'd2, ALU_ADD, 1'b0, 32'h0000_0007, 3'b000, 32'h0000_0007};
        vecs[1] = '{5'd9,  5'd6,  5'd0, ALU_OR,  1'b1, 32'h8000_0000, 3'b010, 32'h0000_0000};
        vecs[2] = '{5'd10, 5'd7,  5'd8, ALU_ADD, 1'b0, 32'h8000_0000, 3'b110, 32'h8000_0000};
        vecs[3] = '{5'd11, 5'd3,  5'd3, ALU_SUB, 1'b0, 32'h0000_0000, 3'b001, 32'h0000_0000};
        vecs[4] = '{5'd5,  5'd5,  5'd5, ALU_ADD, 1'b0, 32'h0000_0014, 3'b000, 32'h0000_0014};
        vecs[5] = '{5'd12, 5'd3,  5'd1, ALU_XOR, 1'b0, 32'h0000_0004, 3'b000, 32'h0000_0004};
        vecs[6] = '{5'd13, 5'd10, 5'd6, ALU_AND, 1'b1, 32'h8000_0000, 3'b010, 32'h0000_0000};
        vecs[7] = '{5'd17, 5'd7,  5'd6, ALU_SUB, 1'b0, 32'hffff_ffff, 3'b110, 32'hffff_ffff};

        rst = 1'b1; step_en = 1'b1; bus.rsp_ready = 1'b1; bus.cmd_valid = 1'b0;
        bus.cmd_wdst = 5'd0; bus.cmd_src1 = 5'd0; bus.cmd_src2 = 5'd0; bus.cmd_op = 4'd0; bus.cmd_nowb = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_state",     32'(state_dbg),      32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready),  32'd1);
        check("rst_busy",      32'(busy),           32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid),  32'd0);
        check("rst_strobes",   32'({bus.rf_rd, bus.rf_wr}), 32'd0);
        check("rst_result",    bus.rsp_result,      32'd0);
        check("rst_flags",     32'(bus.rsp_flags),  32'd0);
        check("rst_addr",      32'({bus.rf_raddr1, bus.rf_raddr2, bus.rf_waddr, bus.alu_op}), 32'd0);

        // Table of free-running commands.
        for (int v = 0; v < 8; v++) begin
            push_cmd(vecs[v].wdst, vecs[v].src1, vecs[v].src2, vecs[v].op, vecs[v].nowb);
            lat = -1; rd_cnt = 0; wr_cnt = 0; wr_addr = 5'd0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (bus.rf_rd) rd_cnt++;
                if (bus.rf_wr) begin wr_cnt++; wr_addr = bus.rf_waddr; end
                if (bus.rsp_valid) begin lat = c; break; end
            end
            check($sformatf("v%0d_latency", v), 32'(lat), vecs[v].nowb ? 32'd3 : 32'd4);
            check($sformatf("v%0d_result", v),  bus.rsp_result, vecs[v].exp_res);
            check($sformatf("v%0d_flags", v),   32'(bus.rsp_flags), 32'(vecs[v].exp_flags));
            check($sformatf("v%0d_rd_cnt", v),  32'(rd_cnt), 32'd1);
            check($sformatf("v%0d_wr_cnt", v),  32'(wr_cnt), vecs[v].nowb ? 32'd0 : 32'd1);
            if (!vecs[v].nowb) check($sformatf("v%0d_waddr", v), 32'(wr_addr), 32'(vecs[v].wdst));
            check($sformatf("v%0d_reg", v), regs[vecs[v].wdst], vecs[v].exp_reg);
        end

        // Back-pressure: three back-to-back commands while responses are stalled.
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        push_cmd(5'd14, 5'd1, 5'd2, ALU_ADD, 1'b0);
        push_cmd(5'd18, 5'd2, 5'd1, ALU_SUB, 1'b1);
        push_cmd(5'd19, 5'd6, 5'd8, ALU_OR,  1'b0);
        repeat (6) @(negedge clk);
        check("bp_state_resp", 32'(state_dbg),     32'd4);
        check("bp_cmd_ready",  32'(bus.cmd_ready), 32'd0);
        check("bp_rsp_valid",  32'(bus.rsp_valid), 32'd1);
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 60 && got < 3; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                res_q[got] = bus.rsp_result;
                flg_q[got] = bus.rsp_flags;
                got++;
            end
        end
        check("bp_count", 32'(got), 32'd3);
        check("bp_res0", res_q[0], 32'h0000_0007);
        check("bp_res1", res_q[1], 32'h0000_0001);
        check("bp_res2", res_q[2], 32'h8000_0001);
        check("bp_flg2", 32'(flg_q[2]), 32'(3'b010));
        repeat (2) @(negedge clk);
        check("bp_cmd_ready_back", 32'(bus.cmd_ready), 32'd1);
        check("bp_busy_clear",     32'(busy),          32'd0);
        check("bp_reg14", regs[14], 32'h0000_0007);
        check("bp_reg18", regs[18], 32'h0000_0000);

        // Step gating with a 1-0-0-1 enable pattern.
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        push_cmd(5'd15, 5'd3, 5'd2, ALU_SUB, 1'b0);
        viol = 0; got = 0; g_res = 32'd0; g_flg = 3'b000;
        for (int c = 0; c < 40; c++) begin
            step_en = pat[c % 4];
            @(negedge clk);
            st_before = int'(state_dbg);
            if (!step_en && (bus.rf_rd || bus.rf_wr)) viol++;
            if (bus.rsp_valid) begin got = 1; g_res = bus.rsp_result; g_flg = bus.rsp_flags; end
            @(posedge clk);
            en_edge = int'(step_en);
            #1;
            if (en_edge == 0 && st_before != 4 && int'(state_dbg) != st_before) viol++;
            if (en_edge == 1 && st_before != 0 && st_before != 4 && int'(state_dbg) == st_before) viol++;
            if (got == 1) break;
        end
        step_en = 1'b1;
        check("gate_done",   32'(got),  32'd1);
        check("gate_viol",   32'(viol), 32'd0);
        check("gate_result", g_res, 32'h0000_0003);
        check("gate_flags",  32'(g_flg), 32'd0);
        check("gate_reg15",  regs[15], 32'h0000_0003);

        // Reset while in WRITE with a second command still queued.
        push_cmd(5'd16, 5'd1, 5'd2, ALU_ADD, 1'b0);
        push_cmd(5'd20, 5'd1, 5'd1, ALU_ADD, 1'b0);
        lat = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (state_dbg == 3'd3) begin lat = c; break; end
        end
        check("rw_reached_write", 32'(lat >= 0), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rw_state",     32'(state_dbg),     32'd0);
        check("rw_rf_wr",     32'(bus.rf_wr),     32'd0);
        check("rw_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rw_busy",      32'(busy),          32'd0);
        check("rw_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rw_result",    bus.rsp_result,     32'd0);
        viol = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (busy || bus.rsp_valid || bus.rf_rd || bus.rf_wr) viol++;
        end
        check("rw_fifo_discarded", 32'(viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit in case a bounded loop is ever bypassed.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
